// File: rtl/alu_seq_pkg.sv
// alu_pkg: opcode and state types shared by the sequential ALU, its
// rotate stage and any block that issues requests to it.
package alu_pkg;

  // 5-bit opcode space; only the first seven codes are defined.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_NOR  = 5'd2,
    OP_NOT  = 5'd3,
    OP_ROL  = 5'd4,
    OP_ROR  = 5'd5,
    OP_PASS = 5'd6
  } op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } state_e;

  // Fill bit replicated across the datapath width for an undefined opcode.
  localparam logic OP_ILLEGAL_RESULT = 1'b0;

  // True for the two opcodes that may take the iterative path.
  function automatic logic is_rotate(input logic [4:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU: a valid/ready request channel
// carrying opcode and operands, and a valid/ready result channel with flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_nonneg;
  logic             out_illegal;

  // Issuer / result consumer side.
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_nonneg, out_illegal
  );

  // ALU side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_nonneg, out_illegal
  );
endinterface

// File: rtl/alu_rot_stage.sv
// alu_rot_stage: combinational rotate of WIDTH bits by 0..ROT_STEP positions,
// left or right, built as one conditional power-of-two rotate per amount bit.
module alu_rot_stage #(
  parameter  int WIDTH    = 32,
  parameter  int ROT_STEP = 4,
  localparam int SW       = $clog2(ROT_STEP) + 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,   // 0: rotate left, 1: rotate right
  input  logic [SW-1:0]    amt_i,   // 0..ROT_STEP
  output logic [WIDTH-1:0] data_o
);

  logic [SW:0][WIDTH-1:0] lvl;

  assign lvl[0] = data_i;

  for (genvar k = 0; k < SW; k++) begin : g_lvl
    localparam int SH = 1 << k;
    logic [WIDTH-1:0] rl;
    logic [WIDTH-1:0] rr;
    // A shift by exactly WIDTH yields zero, so SH == WIDTH degenerates to identity.
    assign rl = (lvl[k] << SH) | (lvl[k] >> (WIDTH - SH));
    assign rr = (lvl[k] >> SH) | (lvl[k] << (WIDTH - SH));
    assign lvl[k+1] = amt_i[k] ? (dir_i ? rr : rl) : lvl[k];
  end

  assign data_o = lvl[SW];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: one-op-at-a-time ALU between register read and writeback.
// Simple ops and zero-distance rotates complete in one cycle; other rotates
// iterate ROT_STEP bits per cycle in the ROTATE state. The output register
// is only ever reloaded when it is empty or draining, so completion never stalls.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ROT_STEP = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  output logic       busy,
  alu_seq_if.slave   bus
);

  localparam int AMT_W = $clog2(WIDTH);
  localparam int SW    = $clog2(ROT_STEP) + 1;

  // Control and iteration state
  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] rem_q;
  logic             dir_q;
  logic             pend_nonneg_q;

  // Output register
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_zero_q;
  logic             out_nonneg_q;
  logic             out_illegal_q;

  // Combinational helpers
  logic             in_ready_d;
  logic             accept;
  logic             drain;
  logic             rot_start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] diff_d;
  logic             nonneg_d;
  logic [WIDTH-1:0] simple_res_d;
  logic             simple_ill_d;
  logic [SW-1:0]    step_d;
  logic [AMT_W-1:0] rem_d;
  logic [WIDTH-1:0] rot_out;

  assign in_ready_d = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !flush;
  assign accept     = bus.in_valid && in_ready_d;
  assign drain      = out_valid_q && bus.out_ready;
  assign amt        = bus.in_a[AMT_W-1:0];
  assign rot_start  = accept && is_rotate(bus.in_op) && (amt != '0);
  assign diff_d     = bus.in_b - bus.in_a;
  assign nonneg_d   = ~diff_d[WIDTH-1];

  // Single-cycle result for every op that does not need iteration.
  always_comb begin
    simple_res_d = {WIDTH{OP_ILLEGAL_RESULT}};
    simple_ill_d = 1'b0;
    case (bus.in_op)
      OP_ADD:         simple_res_d = bus.in_a + bus.in_b;
      OP_SUB:         simple_res_d = diff_d;
      OP_NOR:         simple_res_d = ~(bus.in_a | bus.in_b);
      OP_NOT:         simple_res_d = ~bus.in_a;
      OP_ROL, OP_ROR: simple_res_d = bus.in_b;   // zero-distance rotate
      OP_PASS:        simple_res_d = bus.in_b;
      default:        simple_ill_d = 1'b1;
    endcase
  end

  // Distance covered this iteration: min(ROT_STEP, remaining).
  always_comb begin
    if (int'(rem_q) > ROT_STEP) begin
      step_d = SW'(ROT_STEP);
    end else begin
      step_d = SW'(rem_q);
    end
    rem_d = rem_q - AMT_W'(step_d);
  end

  alu_rot_stage #(
    .WIDTH    (WIDTH),
    .ROT_STEP (ROT_STEP)
  ) u_rot (
    .data_i (work_q),
    .dir_i  (dir_q),
    .amt_i  (step_d),
    .data_o (rot_out)
  );

  // Control FSM plus iteration and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      work_q        <= '0;
      rem_q         <= '0;
      dir_q         <= 1'b0;
      pend_nonneg_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_nonneg_q  <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rot_start) begin
            // Accept implies the output register is empty or draining now.
            state_q       <= ROTATE;
            work_q        <= bus.in_b;
            rem_q         <= amt;
            dir_q         <= (bus.in_op == OP_ROR);
            pend_nonneg_q <= nonneg_d;
            out_valid_q   <= 1'b0;
          end else if (accept) begin
            out_result_q  <= simple_res_d;
            out_zero_q    <= (simple_res_d == '0);
            out_nonneg_q  <= nonneg_d;
            out_illegal_q <= simple_ill_d;
            out_valid_q   <= 1'b1;
          end else if (drain) begin
            out_valid_q <= 1'b0;
          end
        end
        ROTATE: begin
          work_q <= rot_out;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q       <= IDLE;
            out_result_q  <= rot_out;
            out_zero_q    <= (rot_out == '0);
            out_nonneg_q  <= pend_nonneg_q;
            out_illegal_q <= 1'b0;
            out_valid_q   <= 1'b1;
          end else if (drain) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_d;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_nonneg  = out_nonneg_q;
  assign bus.out_illegal = out_illegal_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed scenarios with literal expectations, then a
// random request stream, all continuously compared against a transaction-level
// model (result = f(op, a, b); completion = accept + latency).
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH    = 32;
  localparam int ROT_STEP = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic busy;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(
    .WIDTH    (WIDTH),
    .ROT_STEP (ROT_STEP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .busy    (busy),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int n;
    logic [63:0] t;
    n = int'(a[4:0]);
    case (op)
      5'd0: return a + b;
      5'd1: return b - a;
      5'd2: return ~(a | b);
      5'd3: return ~a;
      5'd4: begin t = {b, b} << n; return t[63:32]; end
      5'd5: begin t = {b, b} >> n; return t[31:0]; end
      5'd6: return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a);
    int n;
    n = int'(a[4:0]);
    if ((op == 5'd4 || op == 5'd5) && n != 0) return 1 + (n + ROT_STEP - 1) / ROT_STEP;
    return 1;
  endfunction

  bit          m_valid  = 0;
  logic [31:0] m_res    = 0;
  bit          m_zero   = 0;
  bit          m_nonneg = 0;
  bit          m_ill    = 0;
  bit          m_pend   = 0;
  int          m_cnt    = 0;
  logic [31:0] p_res    = 0;
  bit          p_nonneg = 0;

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_zero = 0; m_nonneg = 0; m_ill = 0;
    m_pend = 0; m_cnt = 0; p_res = 0; p_nonneg = 0;
  endtask

  task automatic model_step();
    bit          rdy, acc, done;
    logic [31:0] r, d;
    int          lat;
    rdy = !m_pend && (!m_valid || bus.out_ready) && !flush;
    acc = bus.in_valid && rdy;
    if (flush) begin
      m_pend  = 0;
      m_valid = 0;
    end else begin
      done = 0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_res = p_res; m_zero = (p_res == 0); m_nonneg = p_nonneg; m_ill = 0;
          m_valid = 1; m_pend = 0; done = 1;
        end
      end
      if (!done && m_valid && bus.out_ready) m_valid = 0;
      if (acc) begin
        r   = ref_result(bus.in_op, bus.in_a, bus.in_b);
        d   = bus.in_b - bus.in_a;
        lat = ref_latency(bus.in_op, bus.in_a);
        if (lat == 1) begin
          m_res = r; m_zero = (r == 0); m_nonneg = !d[31]; m_ill = (bus.in_op > 5'd6);
          m_valid = 1;
        end else begin
          m_pend = 1; m_cnt = lat - 1; p_res = r; p_nonneg = !d[31];
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("out_valid",   bus.out_valid,   m_valid);
    check("in_ready",    bus.in_ready,    !m_pend && (!m_valid || bus.out_ready) && !flush);
    check("busy",        busy,            m_pend);
    check("out_result",  bus.out_result,  m_res);
    check("out_zero",    bus.out_zero,    m_zero);
    check("out_nonneg",  bus.out_nonneg,  m_nonneg);
    check("out_illegal", bus.out_illegal, m_ill);
  end

  // ---------------- directed helpers ----------------
  // Issue one op, wait for accept, then count cycles until out_valid.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc);
    int guard;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.in_ready && guard < 50);
    if (guard >= 50) timeout("accept_wait");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    busy_cyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
    end while (!bus.out_valid && lat < 50);
    if (lat >= 50) timeout("result_wait");
  endtask

  initial begin
    int lat, bc, vcount, guard;
    reset_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid",  bus.out_valid, 0);
    check("rst_result", bus.out_result, 0);
    check("rst_busy",   busy, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    run_op(5'd0, 32'd5, 32'd7, lat, bc);
    check("add_lat", lat, 1);
    check("add_res", bus.out_result, 32'd12);
    check("add_zero", bus.out_zero, 0);
    check("add_nonneg", bus.out_nonneg, 1);

    run_op(5'd1, 32'd5, 32'd3, lat, bc);
    check("sub_res", bus.out_result, 32'hFFFF_FFFE);
    check("sub_nonneg", bus.out_nonneg, 0);

    run_op(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    check("nor_res", bus.out_result, 32'h0);
    check("nor_zero", bus.out_zero, 1);

    run_op(5'd4, 32'd9, 32'h8000_0001, lat, bc);
    check("rol_lat", lat, 4);
    check("rol_busy", bc, 3);
    check("rol_res", bus.out_result, 32'h0000_0300);

    run_op(5'd5, 32'd31, 32'h1, lat, bc);
    check("ror_lat", lat, 9);
    check("ror_res", bus.out_result, 32'h0000_0002);

    run_op(5'd4, 32'h20, 32'hDEAD_BEEF, lat, bc);
    check("rot0_lat", lat, 1);
    check("rot0_res", bus.out_result, 32'hDEAD_BEEF);

    run_op(5'd17, 32'd1, 32'd2, lat, bc);
    check("ill_lat", lat, 1);
    check("ill_res", bus.out_result, 32'h0);
    check("ill_flag", bus.out_illegal, 1);

    // Backpressure: result held, next request stalled, then back-to-back.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    run_op(5'd0, 32'h10, 32'h20, lat, bc);
    check("bp_lat", lat, 1);
    #1;
    bus.in_valid = 1'b1; bus.in_op = 5'd6; bus.in_a = 32'h0; bus.in_b = 32'h55;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_res", bus.out_result, 32'h30);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_ready", bus.in_ready, 0);
    end
    #2 bus.out_ready = 1'b1;
    #1 check("bp_release_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_res", bus.out_result, 32'h55);
    @(negedge clk);
    check("b2b_drained", bus.out_valid, 0);

    // Flush in the second ROTATE cycle.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.in_op = 5'd4; bus.in_a = 32'd9; bus.in_b = 32'hF;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!bus.in_ready && guard < 20);
    if (guard >= 20) timeout("flush_accept");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    vcount = 0;
    repeat (6) begin
      if (bus.out_valid) vcount++;
      @(negedge clk);
    end
    check("flush_no_valid", vcount, 0);

    // Asynchronous reset in the middle of a rotate.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.in_op = 5'd5; bus.in_a = 32'd31; bus.in_b = 32'h1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", bus.out_valid, 0);
    check("arst_result", bus.out_result, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Random stream with random backpressure and occasional flush.
    repeat (3000) begin
      int r;
      @(posedge clk);
      #1;
      r = int'($urandom_range(0, 15));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_op     = (r < 14) ? 5'(r % 7) : 5'($urandom_range(7, 31));
      bus.in_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      bus.in_b      = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised sequential successor to the datapath ALU. Executes one operation at a time behind valid/ready handshakes on input and output. Simple ops complete in one cycle. Rotates of any amount (mod WIDTH) run iteratively, ROT_STEP bits per cycle. Sits between register-read and writeback; also supplies the branch condition (b - a >= 0) and a zero flag.

Parameters:
WIDTH, 32, datapath width; power of 2, >= 8
ROT_STEP, 4, max rotate distance per iteration cycle; power of 2, 1..WIDTH
AMT_W, $clog2(WIDTH), derived localparam; rotate-amount width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of in-flight op and pending result
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
in_op  in  5  opcode (alu_pkg::op_e)
in_a  in  WIDTH  operand A; low AMT_W bits are the rotate amount for ROL/ROR
in_b  in  WIDTH  operand B; value rotated for ROL/ROR
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  result
out_zero  out  1  out_result == 0
out_nonneg  out  1  MSB of (in_b - in_a) == 0, captured at accept
out_illegal  out  1  opcode was unused
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, out_result=0, out_zero=0, out_nonneg=0, out_illegal=0, busy=0. Work/count regs = 0.
- Opcodes: ADD=0 (a+b), SUB=1 (b-a), NOR=2 (~(a|b)), NOT=3 (~a), ROL=4 (b rotl amt), ROR=5 (b rotr amt), PASS=6 (b). Codes 7..31 are illegal: result 0, out_illegal=1, latency 1.
- Arithmetic: modulo 2^WIDTH, no carry or overflow out. amt = in_a[AMT_W-1:0]. Upper bits of in_a are ignored for rotates.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush. Accept = in_valid & in_ready.
- Handshake: a dropped in_valid without accept has no effect. Inputs are sampled only on accept.
- States are IDLE and ROTATE.
- IDLE, accept of a non-rotate op, or a rotate with amt==0:
  - Result registered at that edge; out_valid=1 next cycle (latency 1).
  - Stays in IDLE. Back-to-back issue is allowed when out_ready=1.
- IDLE, accept of a rotate with amt!=0:
  - work<=in_b, remaining<=amt, dir latched, nonneg latched; state goes to ROTATE.
- ROTATE, each cycle:
  - step=min(ROT_STEP, remaining); work rotates by step; remaining decrements by step.
  - When remaining reaches 0: out_result<=rotated value, out_valid<=1, state goes to IDLE.
  - Latency = 1 + ceil(amt/ROT_STEP) cycles from the accept cycle.
- Output hold: while out_valid & !out_ready, out_result and all flags are stable. Cleared when out_valid & out_ready with no new completion on that edge. Completion and drain on the same edge: the new result is loaded and out_valid stays 1.
- ROTATE is entered only when the output register is free or draining. Completion is therefore never blocked.
- flush: has priority over everything except reset. Next edge: state=IDLE, out_valid=0, remaining=0. A request presented in the same cycle is not accepted (in_ready=0).
- Reset mid-ROTATE: immediate return to reset values; the in-flight op is lost.
- out_zero is derived from the registered result. out_nonneg is computed at accept for every op.

Decomposition:
- Package alu_pkg: op_e enum (5-bit), state_e {IDLE, ROTATE}, OP_ILLEGAL_RESULT constant, is_rotate() function.
- Sub-module alu_rot_stage (combinational): rotates WIDTH bits left/right by 0..ROT_STEP. Uses log2(ROT_STEP)+1 mux levels, parametrised by WIDTH and ROT_STEP.
- Simple-op datapath stays inline.

Test Plan:
- Reset, then ADD a=5 b=7, out_ready=1 -> out_valid one cycle after accept, result=12, zero=0, nonneg=1.
- SUB a=5 b=3 -> result=0xFFFFFFFE, nonneg=0. NOR a=b=0xFFFFFFFF -> result=0, zero=1.
- ROL a=9 b=0x80000001, ROT_STEP=4 -> busy for 3 cycles, result=0x00000300 at latency 4. ROR a=31 b=0x1 -> 0x00000002 at latency 9. Rotate with amt=0 -> latency 1, result=b.
- Backpressure: out_ready=0 after an ADD completes -> result held stable and in_ready=0 for 5 cycles. Then out_ready=1 with a new in_valid -> back-to-back results, no loss or duplication.
- flush in the 2nd ROTATE cycle -> out_valid never rises, IDLE next cycle. reset_n low mid-ROTATE -> all outputs 0 asynchronously.
- Illegal opcode 17 -> result=0, out_illegal=1, latency 1. Random constrained stream of ops vs reference model with random out_ready -> no mismatches.
